ls245_bus_ctrl: RTL

Synchronous bus-cycle controller that sits directly upstream of an ls245 octal transceiver on the CPU data bus. It generates the transceiver's _DIR and _OE, drives the A side during writes, and latches the A side during reads. Each request becomes a fixed-length setup / enable / recovery sequence, so the transceiver never changes direction while enabled and never fights the local A-side driver.

---
 rtl/ls245_bus_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/ls245_bus_ctrl.sv
// Bus-cycle sequencer for an ls245 transceiver: SETUP -> ACTIVE (OE low) -> RECOVER -> IDLE,
// so direction only ever changes while the transceiver is disabled.
module ls245_bus_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] a_in_i,
  output logic [7:0] a_out_o,
  output logic       a_en_o,
  output logic       dir_o,
  output logic       oe_o,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       busy_o,
  output logic [1:0] state_o
);

  localparam int MAX_C = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    a_out_q;
  logic [7:0]    rdata_q;
  logic          a_en_q;
  logic          dir_q;
  logic          oe_q;
  logic          ack_q;
  logic          busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_out_q <= 8'h00;
      rdata_q <= 8'h00;
      a_en_q  <= 1'b0;
      dir_q   <= 1'b0;
      oe_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          oe_q   <= 1'b1;
          a_en_q <= 1'b0;
          ack_q  <= 1'b0;
          if (req_i) begin
            state_q <= S_SETUP;
            dir_q   <= wr_i;
            a_out_q <= wdata_i;
            a_en_q  <= wr_i;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_ACTIVE;
          oe_q    <= 1'b0;
          cnt_q   <= CW'(HOLD_CYCLES - 1);
        end
        S_ACTIVE: begin
          if (cnt_q == '0) begin
            // Read data is captured on the same edge that raises OE.
            state_q <= S_RECOVER;
            oe_q    <= 1'b1;
            a_en_q  <= 1'b0;
            if (!dir_q) rdata_q <= a_in_i;
            cnt_q   <= CW'(TURN_CYCLES - 1);
            ack_q   <= (TURN_CYCLES == 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RECOVER: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            ack_q <= (cnt_q == CW'(1));
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_out_o = a_out_q;
  assign a_en_o  = a_en_q;
  assign dir_o   = dir_q;
  assign oe_o    = oe_q;
  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule
